// File: rtl/inbyte115200_1_8_if.sv
// Call/return and serial-line signals of the 8N1 byte receiver.
// The DUT takes the slave side and the caller takes the master side.
interface inbyte115200_1_8_if;
    logic       start;
    logic       inchan;
    logic [7:0] result;
    logic       result_ready;
    logic       overrun;

    modport master (output start, output inchan,
                    input  result, input result_ready, input overrun);
    modport slave  (input  start, input inchan,
                    output result, output result_ready, output overrun);
endinterface

// File: rtl/inbyte115200_1_8.sv
// 8N1 115200 bps receiver with 16x oversampling, a small FIFO and a call/return front end.
// Define INBYTE_FRAMING_CHECK_EN to discard frames whose stop bit reads 0.
module inbyte115200_1_8 #(
    parameter int OS_DIV     = 54,
    parameter int FIFO_DEPTH = 4,
    parameter int FIFO_AW    = 2
) (
    input logic               clk,
    input logic               wb_rst_i,
    inbyte115200_1_8_if.slave bus
);
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK} rx_state_e;
    typedef enum logic [1:0] {ST_READY = 2'b00, ST_WAITING = 2'b01,
                              ST_NEVERNEVER = 2'b11} top_state_e;

    localparam int                TW       = $clog2(OS_DIV);
    localparam logic [TW-1:0]     T_RELOAD = TW'(OS_DIV - 1);
    localparam logic [FIFO_AW:0]  FULL_CNT = (FIFO_AW + 1)'(FIFO_DEPTH);

    logic             sync1_q, sync2_q, prev_q;
    logic [TW-1:0]    tick_cnt_q, tick_cnt_d;
    logic [3:0]       sub_q, sub_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    rx_state_e        rx_state_q, rx_state_d;
    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0] count_q, count_d;
    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [7:0]       mem_d [FIFO_DEPTH];
    top_state_e       top_state_q, top_state_d;
    logic [7:0]       result_q, result_d;
    logic             overrun_q, overrun_d;

    logic tick, rx_push, push_ok, pop, empty, full;

    assign tick  = (tick_cnt_q == '0);
    assign empty = (count_q == '0);
    assign full  = (count_q == FULL_CNT);

    // Receiver: tick counter is held at reload in idle so ticks align to the start edge.
    always_comb begin
        tick_cnt_d = (rx_state_q == RX_IDLE || tick) ? T_RELOAD : tick_cnt_q - TW'(1);
        rx_state_d = rx_state_q;
        sub_d      = sub_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        rx_push    = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (prev_q && !sync2_q) begin
                    rx_state_d = RX_START;
                    sub_d      = 4'd0;
                end
            end
            RX_START: begin
                if (tick) begin
                    sub_d = sub_q + 4'd1;
                    if (sub_q == 4'd7) begin
                        sub_d      = 4'd0;
                        bit_d      = 3'd0;
                        rx_state_d = sync2_q ? RX_IDLE : RX_DATA;
                    end
                end
            end
            RX_DATA: begin
                if (tick) begin
                    sub_d = sub_q + 4'd1;
                    if (sub_q == 4'd15) begin
                        shift_d = {sync2_q, shift_q[7:1]};
                        bit_d   = bit_q + 3'd1;
                        if (bit_q == 3'd7) rx_state_d = RX_STOP;
                    end
                end
            end
            RX_STOP: begin
                if (tick) begin
                    sub_d = sub_q + 4'd1;
                    if (sub_q == 4'd15) begin
`ifdef INBYTE_FRAMING_CHECK_EN
                        rx_push    = sync2_q;
`else
                        rx_push    = 1'b1;
`endif
                        rx_state_d = sync2_q ? RX_IDLE : RX_BREAK;
                    end
                end
            end
            RX_BREAK: begin
                if (tick && sync2_q) rx_state_d = RX_IDLE;
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // FIFO and call/return front end; start always wins over a pending pop.
    always_comb begin
        pop       = (top_state_q == ST_WAITING) && !bus.start && !empty;
        push_ok   = rx_push && (!full || pop);
        mem_d     = mem_q;
        if (push_ok) mem_d[wr_ptr_q] = shift_q;
        wr_ptr_d  = wr_ptr_q + {{(FIFO_AW-1){1'b0}}, push_ok};
        rd_ptr_d  = rd_ptr_q + {{(FIFO_AW-1){1'b0}}, pop};
        count_d   = count_q + {{FIFO_AW{1'b0}}, push_ok} - {{FIFO_AW{1'b0}}, pop};
        overrun_d = bus.start ? 1'b0 : overrun_q;
        if (rx_push && !push_ok) overrun_d = 1'b1;

        top_state_d = top_state_q;
        result_d    = result_q;
        if (bus.start) begin
            top_state_d = ST_WAITING;
        end else begin
            case (top_state_q)
                ST_WAITING: begin
                    if (!empty) begin
                        result_d    = mem_q[rd_ptr_q];
                        top_state_d = ST_READY;
                    end
                end
                ST_NEVERNEVER: top_state_d = ST_READY;
                default:       top_state_d = top_state_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            prev_q      <= 1'b1;
            tick_cnt_q  <= T_RELOAD;
            sub_q       <= 4'd0;
            bit_q       <= 3'd0;
            shift_q     <= 8'h00;
            rx_state_q  <= RX_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            mem_q       <= '{default: 8'h00};
            top_state_q <= ST_READY;
            result_q    <= 8'h00;
            overrun_q   <= 1'b0;
        end else begin
            sync1_q     <= bus.inchan;
            sync2_q     <= sync1_q;
            prev_q      <= sync2_q;
            tick_cnt_q  <= tick_cnt_d;
            sub_q       <= sub_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            rx_state_q  <= rx_state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            mem_q       <= mem_d;
            top_state_q <= top_state_d;
            result_q    <= result_d;
            overrun_q   <= overrun_d;
        end
    end

    assign bus.result       = result_q;
    assign bus.result_ready = (top_state_q == ST_READY) & ~bus.start;
    assign bus.overrun      = overrun_q;
endmodule
